// File: rtl/candle_ctrl.sv
// Candle LED controller: mode FSM, saturating brightness level and a
// period-latched PWM whose duty is dimmed by an LFSR in flicker mode.
module candle_ctrl #(
    parameter int unsigned LEVEL_BITS      = 3,
    parameter int unsigned INIT_LEVEL      = 3,
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned PRESCALE        = 4,
    parameter int unsigned FLICKER_PERIODS = 4,
    parameter int unsigned FLICKER_SHIFT   = 2
) (
    input  logic                  clk_50MHz,
    input  logic                  rst,
    input  logic                  up,
    input  logic                  down,
    input  logic                  mode,
    output logic [1:0]            state,
    output logic [LEVEL_BITS-1:0] level,
    output logic                  led_pwm
);

    localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned FC_W     = (FLICKER_PERIODS > 1) ? $clog2(FLICKER_PERIODS) : 1;
    localparam int unsigned LOW_BITS = PWM_BITS - LEVEL_BITS;
    localparam int unsigned DW       = (PWM_BITS > 8) ? PWM_BITS : 8;

    typedef enum logic [1:0] {
        StOff     = 2'b00,
        StSteady  = 2'b01,
        StFlicker = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [LEVEL_BITS-1:0] level_q, level_d;
    logic [PS_W-1:0]       presc_q;
    logic [PWM_BITS-1:0]   pwm_cnt_q;
    logic [PWM_BITS-1:0]   duty_latched_q;
    logic [FC_W-1:0]       flicker_cnt_q;
    logic [15:0]           lfsr_q;
    logic                  led_q;

    logic                  presc_wrap;
    logic                  period_start;
    logic [15:0]           lfsr_step;
    logic [PWM_BITS-1:0]   base_duty;
    logic [PWM_BITS-1:0]   flicker_duty;
    logic [PWM_BITS-1:0]   duty;
    logic [7:0]            dim8;
    logic [DW-1:0]         base_w;
    logic [DW-1:0]         dim_w;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StOff:     state_d = mode ? StSteady : StOff;
            StSteady:  state_d = mode ? StFlicker : StSteady;
            StFlicker: state_d = mode ? StOff : StFlicker;
            default:   state_d = StOff;
        endcase
    end

    // Gating uses the pre-edge state, so mode+up from OFF leaves level alone.
    always_comb begin
        level_d = level_q;
        if (state_q != StOff && (up ^ down)) begin
            if (up && level_q != '1) begin
                level_d = level_q + 1'b1;
            end else if (down && level_q != '0) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_comb begin
        base_duty    = {level_q, {LOW_BITS{1'b1}}};
        dim8         = lfsr_q[7:0] >> FLICKER_SHIFT;
        base_w       = DW'(base_duty);
        dim_w        = DW'(dim8);
        flicker_duty = (dim_w > base_w) ? '0 : PWM_BITS'(base_w - dim_w);
        case (state_q)
            StSteady:  duty = base_duty;
            StFlicker: duty = flicker_duty;
            default:   duty = '0;
        endcase
    end

    assign presc_wrap   = (presc_q == PS_W'(PRESCALE - 1));
    assign period_start = presc_wrap && (pwm_cnt_q == '1);
    assign lfsr_step    = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q        <= StOff;
            level_q        <= LEVEL_BITS'(INIT_LEVEL);
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            duty_latched_q <= '0;
            flicker_cnt_q  <= '0;
            lfsr_q         <= 16'hACE1;
            led_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
            if (presc_wrap) begin
                pwm_cnt_q <= pwm_cnt_q + 1'b1;
            end
            if (period_start) begin
                duty_latched_q <= duty;
                if (flicker_cnt_q == FC_W'(FLICKER_PERIODS - 1)) begin
                    flicker_cnt_q <= '0;
                    lfsr_q        <= lfsr_step;
                end else begin
                    flicker_cnt_q <= flicker_cnt_q + 1'b1;
                end
            end
            led_q <= (state_q != StOff) && (pwm_cnt_q < duty_latched_q);
        end
    end

    assign state   = state_q;
    assign level   = level_q;
    assign led_pwm = led_q;

endmodule

// File: tb/tb_candle_ctrl.sv
// Directed bench for candle_ctrl: one fast instance (PRESCALE=1, flicker every
// period) for most checks, plus a default-parameter instance for the prescaler.
module tb_candle_ctrl;

    logic       clk_50MHz = 1'b0;
    logic       rst  = 1'b1;
    logic       up   = 1'b0;
    logic       down = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] state, state4;
    logic [2:0] level, level4;
    logic       led_pwm, led4;

    int passed   = 0;
    int total    = 0;
    int since_rst = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    candle_ctrl #(.PRESCALE(1), .FLICKER_PERIODS(1)) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .up        (up),
        .down      (down),
        .mode      (mode),
        .state     (state),
        .level     (level),
        .led_pwm   (led_pwm)
    );

    candle_ctrl dut4 (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .up        (up),
        .down      (down),
        .mode      (mode),
        .state     (state4),
        .level     (level4),
        .led_pwm   (led4)
    );

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Window k (starting after the k-th period start) uses the seed stepped k-1 times.
    function automatic int exp_flicker(input int base, input int k);
        logic [15:0] s;
        int d;
        s = 16'hACE1;
        for (int i = 1; i < k; i++) s = lstep(s);
        d = base - (int'(s[7:0]) >> 2);
        return (d < 0) ? 0 : d;
    endfunction

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
        since_rst++;
    endtask

    task automatic pulse(input logic u, input logic d, input logic m);
        up = u; down = d; mode = m;
        tick();
        up = 1'b0; down = 1'b0; mode = 1'b0;
        tick();
    endtask

    task automatic align(input int per);
        do tick(); while (since_rst % per != 0);
    endtask

    task automatic count(input int n, output int h, output int h4);
        h = 0; h4 = 0;
        repeat (n) begin
            tick();
            h  += int'(led_pwm);
            h4 += int'(led4);
        end
    endtask

    task automatic test_reset();
        int h, h4;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        since_rst = 0;
        total++; if (state !== 2'b00) $display("FAIL reset_state got %0d want 0", state); else passed++;
        total++; if (level !== 3'd3) $display("FAIL reset_level got %0d want 3", level); else passed++;
        total++; if (led_pwm !== 1'b0) $display("FAIL reset_led got %b want 0", led_pwm); else passed++;
        total++; if (state4 !== 2'b00 || level4 !== 3'd3) $display("FAIL reset_dut4 got %0d/%0d want 0/3", state4, level4); else passed++;
        count(1024, h, h4);
        total++; if (h !== 0) $display("FAIL reset_idle_led got %0d want 0", h); else passed++;
        total++; if (h4 !== 0) $display("FAIL reset_idle_led4 got %0d want 0", h4); else passed++;
    endtask

    task automatic test_steady();
        int h, h4;
        pulse(1'b0, 1'b0, 1'b1);
        total++; if (state !== 2'b01) $display("FAIL steady_state got %0d want 1", state); else passed++;
        align(256);
        count(256, h, h4);
        total++; if (h !== 127) $display("FAIL steady_l3_high got %0d want 127", h); else passed++;
        align(1024);
        count(1024, h, h4);
        total++; if (h4 !== 508) $display("FAIL prescale4_high got %0d want 508", h4); else passed++;
        total++; if (h !== 508) $display("FAIL prescale1_4periods got %0d want 508", h); else passed++;
    endtask

    task automatic test_level();
        int h, h4;
        repeat (6) pulse(1'b1, 1'b0, 1'b0);
        total++; if (level !== 3'd7) $display("FAIL up_saturate got %0d want 7", level); else passed++;
        align(256);
        count(256, h, h4);
        total++; if (h !== 255) $display("FAIL level7_high got %0d want 255", h); else passed++;
        repeat (10) pulse(1'b0, 1'b1, 1'b0);
        total++; if (level !== 3'd0) $display("FAIL down_saturate got %0d want 0", level); else passed++;
        total++; if (level4 !== 3'd0) $display("FAIL down_saturate_dut4 got %0d want 0", level4); else passed++;
        align(256);
        count(256, h, h4);
        total++; if (h !== 31) $display("FAIL level0_high got %0d want 31", h); else passed++;
    endtask

    task automatic test_same_cycle();
        pulse(1'b1, 1'b0, 1'b0);
        total++; if (level !== 3'd1) $display("FAIL up_once got %0d want 1", level); else passed++;
        pulse(1'b1, 1'b1, 1'b0);
        total++; if (level !== 3'd1) $display("FAIL up_down_same got %0d want 1", level); else passed++;
        pulse(1'b0, 1'b1, 1'b0);
        total++; if (level !== 3'd0) $display("FAIL down_once got %0d want 0", level); else passed++;
    endtask

    task automatic test_flicker();
        int h, h4, k, e;
        pulse(1'b0, 1'b0, 1'b1);
        total++; if (state !== 2'b10) $display("FAIL flicker_state got %0d want 2", state); else passed++;
        for (int w = 0; w < 4; w++) begin
            align(256);
            k = since_rst / 256;
            e = exp_flicker(31, k);
            count(256, h, h4);
            total++; if (h !== e) $display("FAIL flicker_l0_w%0d got %0d want %0d", w, h, e); else passed++;
        end
    endtask

    task automatic test_off();
        int h, h4;
        pulse(1'b0, 1'b0, 1'b1);
        total++; if (state !== 2'b00) $display("FAIL wrap_to_off got %0d want 0", state); else passed++;
        pulse(1'b1, 1'b0, 1'b0);
        total++; if (level !== 3'd0) $display("FAIL up_in_off got %0d want 0", level); else passed++;
        align(256);
        count(256, h, h4);
        total++; if (h !== 0) $display("FAIL off_high got %0d want 0", h); else passed++;
        pulse(1'b1, 1'b0, 1'b1);
        total++; if (state !== 2'b01 || level !== 3'd0) $display("FAIL mode_up_from_off got %0d/%0d want 1/0", state, level); else passed++;
    endtask

    task automatic test_enter_off();
        repeat (7) pulse(1'b1, 1'b0, 1'b0);
        total++; if (level !== 3'd7) $display("FAIL up_to_7 got %0d want 7", level); else passed++;
        pulse(1'b0, 1'b0, 1'b1);
        align(256);
        repeat (10) tick();
        total++; if (led_pwm !== 1'b1) $display("FAIL flicker_l7_led got %b want 1", led_pwm); else passed++;
        mode = 1'b1;
        tick();
        mode = 1'b0;
        total++; if (state !== 2'b00) $display("FAIL enter_off_state got %0d want 0", state); else passed++;
        tick();
        total++; if (led_pwm !== 1'b0) $display("FAIL enter_off_led got %b want 0", led_pwm); else passed++;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int h, h4, e;
        align(256);
        repeat (50) tick();
        total++; if (led_pwm !== 1'b1) $display("FAIL pre_rst_led got %b want 1", led_pwm); else passed++;
        rst = 1'b1;
        tick();
        total++; if (state !== 2'b00 || level !== 3'd3) $display("FAIL mid_rst_state got %0d/%0d want 0/3", state, level); else passed++;
        total++; if (led_pwm !== 1'b0) $display("FAIL mid_rst_led got %b want 0", led_pwm); else passed++;
        total++; if (dut.lfsr_q !== 16'hACE1) $display("FAIL mid_rst_lfsr got %h want ace1", dut.lfsr_q); else passed++;
        total++; if (dut.pwm_cnt_q !== 8'd0 || dut.duty_latched_q !== 8'd0 || dut.flicker_cnt_q !== 1'b0)
            $display("FAIL mid_rst_counters got %0d/%0d/%0d want 0/0/0", dut.pwm_cnt_q, dut.duty_latched_q, dut.flicker_cnt_q);
        else passed++;
        total++; if (dut4.presc_q !== 2'd0 || dut4.pwm_cnt_q !== 8'd0 || dut4.flicker_cnt_q !== 2'd0)
            $display("FAIL mid_rst_dut4_counters got %0d/%0d/%0d want 0/0/0", dut4.presc_q, dut4.pwm_cnt_q, dut4.flicker_cnt_q);
        else passed++;
        rst = 1'b0;
        since_rst = 0;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        align(256);
        e = exp_flicker(127, since_rst / 256);
        count(256, h, h4);
        total++; if (h !== e) $display("FAIL post_rst_flicker got %0d want %0d", h, e); else passed++;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_level();
        test_same_cycle();
        test_flicker();
        test_off();
        test_enter_off();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/candle_ctrl.md
# candle_ctrl

Candle mode and brightness controller sitting directly downstream of the button debounce/one-shot stages. It consumes three single-cycle button pulses (up, down, mode), maintains an operating mode and a brightness level, and drives a single LED through a glitch-free PWM. In FLICKER mode the duty is modulated by an LFSR so the LED imitates a candle flame.

## Interface
Parameters:
- LEVEL_BITS, 3, width of brightness level; LEVELS = 2^LEVEL_BITS
- INIT_LEVEL, 3, level after reset
- PWM_BITS, 8, PWM counter width; must exceed LEVEL_BITS
- PRESCALE, 4, clk_50MHz cycles per PWM count (>=1)
- FLICKER_PERIODS, 4, PWM periods between LFSR advances (>=1)
- FLICKER_SHIFT, 2, right-shift applied to LFSR byte before subtraction

Ports:
- clk_50MHz  input  1  system clock; all state changes on its rising edge
- rst  input  1  reset: synchronous, active-high
- up  input  1  one-cycle pulse, raise level
- down  input  1  one-cycle pulse, lower level
- mode  input  1  one-cycle pulse, advance mode
- state  output  2  00 OFF, 01 STEADY, 10 FLICKER
- level  output  LEVEL_BITS  current brightness level
- led_pwm  output  1  registered LED drive

## Operation
- Reset (rst high at a rising edge): state=OFF, level=INIT_LEVEL, prescaler=0, pwm_cnt=0, duty_latched=0, flicker_cnt=0, lfsr=16'hACE1, led_pwm=0. rst overrides every other input, including mid-PWM-period.
- Mode FSM on mode pulse: OFF->STEADY->FLICKER->OFF. Encoding 11 unreachable; if entered, next edge goes to OFF.
- Level: up increments, saturating at LEVELS-1; down decrements, saturating at 0. up and down in the same cycle: no change. up/down ignored while current (pre-edge) state is OFF. mode with up/down in one cycle: both applied, gating uses the pre-edge state.
- Base duty = {level, all-ones in the low PWM_BITS-LEVEL_BITS bits}; defaults give 31..255.
- STEADY duty = base. FLICKER duty = base - (lfsr[7:0] >> FLICKER_SHIFT), clamped at 0 (no wrap). OFF duty = 0.
- PWM: prescaler counts 0..PRESCALE-1; on wrap pwm_cnt increments, wrapping 2^PWM_BITS-1 -> 0. At the edge where pwm_cnt wraps to 0, duty_latched loads the current duty; duty never changes mid-period.
- led_pwm <= (state != OFF) && (pwm_cnt < duty_latched). Duty 255 gives 255/256 high; duty 0 gives constant low.
- LFSR: 16-bit Galois, right shift, mask 16'hB400 (x^16+x^14+x^13+x^11+1). flicker_cnt counts PWM-period starts; when it reaches FLICKER_PERIODS-1 it returns to 0 and the LFSR advances one step. LFSR runs in all states (only its use is mode-gated).

## Timing
- Pulse sampled at edge n: state/level outputs change after edge n.
- New duty takes effect at the next PWM period start; led_pwm reflects it one cycle later (registered compare).
- Entering OFF: led_pwm low from the edge after the state change, regardless of period position.
- PWM period = PRESCALE * 2^PWM_BITS cycles (1024 at defaults, ~48.8 kHz).
- Inputs must be single-cycle pulses; a level held high for k cycles counts as k events.

## Test plan
- Reset: after rst, state=00, level=3, led_pwm=0 for a full period with no pulses.
- PRESCALE=1: mode pulse -> state=01; after one full period, count led_pwm high cycles per 256-cycle period = 127 (level 3).
- From level 3 issue 6 up pulses -> level=7, high count 255; then 10 down pulses -> level=0, high count 31; up in OFF -> level unchanged.
- up and down asserted same cycle in STEADY -> level unchanged; mode+up same cycle from OFF -> state=01, level unchanged.
- FLICKER at level 0, FLICKER_PERIODS=1: per-period high count equals max(0, 31 - (lfsr[7:0]>>2)) matching a reference LFSR model from seed 16'hACE1; duty never wraps above 31.
- Assert rst mid-period in FLICKER with duty 200 -> next edge led_pwm=0, state=00, lfsr=16'hACE1, counters 0.
